// File: rtl/servo_pkg.sv
// Shared constants and cycle-count helpers for the servo PWM bank.
// Everything is a pure function of the bank parameters.
package servo_pkg;

    // Cycles spanned by a duration given in microseconds.
    function automatic int cyc_of_us(input int clk_rate, input int us);
        return (clk_rate / 1000000) * us;
    endfunction

    // Clock cycles added to the pulse per position LSB.
    function automatic int step_cyc(
        input int clk_rate,
        input int min_us,
        input int max_us,
        input int pos_w
    );
        return (cyc_of_us(clk_rate, max_us) - cyc_of_us(clk_rate, min_us))
               >> pos_w;
    endfunction

    // Mid-scale position used on reset.
    function automatic int center(input int pos_w);
        return 1 << (pos_w - 1);
    endfunction

    // Counter width able to hold 0..frame_cyc-1.
    function automatic int cnt_width(input int frame_cyc);
        return (frame_cyc > 2) ? $clog2(frame_cyc) : 1;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: shadow/target/current position, slew limiter,
// pulse threshold and the registered PWM output bit.
//  clk, rst_n       clock, synchronous active-low reset
//  wr_en_i/wr_pos_i shadow write strobe and value
//  commit_i         copy shadow into target
//  frame_end_i      last cycle of the frame: advance cur and threshold
//  frame_cnt_i      shared frame counter
//  servo_out_o      registered PWM output
//  at_target_o      cur == target (combinational)
module servo_channel
    import servo_pkg::*;
#(
    parameter int POS_WIDTH = 8,
    parameter int CNT_W     = 20,
    parameter int MIN_CYC   = 50000,
    parameter int STEP_CYC  = 195,
    parameter int SLEW_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [POS_WIDTH-1:0] wr_pos_i,
    input  logic                 commit_i,
    input  logic                 frame_end_i,
    input  logic [CNT_W-1:0]     frame_cnt_i,
    output logic                 servo_out_o,
    output logic                 at_target_o
);

    localparam logic [POS_WIDTH-1:0] CENTER_P =
        POS_WIDTH'(center(POS_WIDTH));
    localparam int STEP_LIM =
        (SLEW_STEP > (1 << POS_WIDTH)) ? (1 << POS_WIDTH) : SLEW_STEP;
    localparam logic [POS_WIDTH:0] STEP_V = (POS_WIDTH + 1)'(STEP_LIM);
    localparam logic [CNT_W-1:0] THRESH_RST =
        CNT_W'(MIN_CYC + center(POS_WIDTH) * STEP_CYC);

    logic [POS_WIDTH-1:0] shadow_q, shadow_d;
    logic [POS_WIDTH-1:0] target_q, target_d;
    logic [POS_WIDTH-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]     thresh_q, thresh_d;
    logic                 out_q, out_d;

    logic                 up;
    logic [POS_WIDTH:0]   diff;
    logic [POS_WIDTH:0]   step;
    logic [POS_WIDTH-1:0] cur_step;

    always_comb begin
        up   = target_q > cur_q;
        diff = up ? ({1'b0, target_q} - {1'b0, cur_q})
                  : ({1'b0, cur_q} - {1'b0, target_q});
        // Zero step limit means jump straight to target.
        if (SLEW_STEP == 0 || diff < STEP_V) begin
            step = diff;
        end else begin
            step = STEP_V;
        end
        // step never exceeds diff, which fits in POS_WIDTH bits.
        cur_step = up ? (cur_q + step[POS_WIDTH-1:0])
                      : (cur_q - step[POS_WIDTH-1:0]);

        shadow_d = wr_en_i ? wr_pos_i : shadow_q;
        // Commit sees the shadow before any same-cycle write.
        target_d = commit_i ? shadow_q : target_q;
        cur_d    = cur_q;
        thresh_d = thresh_q;
        if (frame_end_i) begin
            cur_d    = cur_step;
            thresh_d = CNT_W'(MIN_CYC)
                     + CNT_W'(cur_step) * CNT_W'(STEP_CYC);
        end
        // Threshold only moves on the frame's last cycle, so a
        // pulse width is fixed for the whole frame.
        out_d = frame_cnt_i < thresh_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= CENTER_P;
            target_q <= CENTER_P;
            cur_q    <= CENTER_P;
            thresh_q <= THRESH_RST;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            thresh_q <= thresh_d;
            out_q    <= out_d;
        end
    end

    assign servo_out_o = out_q;
    assign at_target_o = cur_q == target_q;

endmodule

// File: rtl/servo_bank_ctrl.sv
// N-channel servo PWM bank with shadow writes, atomic commit and slew.
//  clk, rst_n    clock, synchronous active-low reset
//  servo_num/servo_pos/new_pos  shadow write port
//  trigger       asynchronous commit request (rising edge)
//  servo_out     registered PWM outputs
//  commit_pulse  shadow copied to target
//  wr_err        write to a channel index that does not exist
//  frame_start   frame counter wrapped to 0
//  settled       every channel at its target
module servo_bank_ctrl
    import servo_pkg::*;
#(
    parameter int NUM_SERVOS   = 8,
    parameter int POS_WIDTH    = 8,
    parameter int CLK_RATE     = 50000000,
    parameter int FRAME_US     = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_PULSE_US = 2000,
    parameter int SLEW_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            servo_num,
    input  logic [POS_WIDTH-1:0]  servo_pos,
    input  logic                  new_pos,
    input  logic                  trigger,
    output logic [NUM_SERVOS-1:0] servo_out,
    output logic                  commit_pulse,
    output logic                  wr_err,
    output logic                  frame_start,
    output logic                  settled
);

    localparam int FRAME_CYC = cyc_of_us(CLK_RATE, FRAME_US);
    localparam int MIN_CYC   = cyc_of_us(CLK_RATE, MIN_PULSE_US);
    localparam int STEP_CYC  =
        step_cyc(CLK_RATE, MIN_PULSE_US, MAX_PULSE_US, POS_WIDTH);
    localparam int CNT_W     = cnt_width(FRAME_CYC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYC - 1);

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             trig_s1_q, trig_s2_q, trig_s3_q;
    logic             commit_q, commit_d;
    logic             wr_err_q, wr_err_d;
    logic             settled_q, settled_d;

    logic                  frame_end;
    logic                  wr_ok;
    logic [NUM_SERVOS-1:0] at_target;

    always_comb begin
        frame_end     = frame_cnt_q == LAST_CNT;
        frame_cnt_d   = frame_end ? '0 : frame_cnt_q + 1'b1;
        frame_start_d = frame_end;
        // Rising edge on the synchronised trigger.
        commit_d      = trig_s2_q & ~trig_s3_q;
        // 7-bit compare keeps NUM_SERVOS = 64 representable.
        wr_ok         = new_pos && ({1'b0, servo_num} < 7'(NUM_SERVOS));
        wr_err_d      = new_pos && !wr_ok;
        settled_d     = &at_target;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            trig_s1_q     <= 1'b0;
            trig_s2_q     <= 1'b0;
            trig_s3_q     <= 1'b0;
            commit_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            settled_q     <= 1'b1;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            trig_s1_q     <= trigger;
            trig_s2_q     <= trig_s1_q;
            trig_s3_q     <= trig_s2_q;
            commit_q      <= commit_d;
            wr_err_q      <= wr_err_d;
            settled_q     <= settled_d;
        end
    end

    for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
        servo_channel #(
            .POS_WIDTH (POS_WIDTH),
            .CNT_W     (CNT_W),
            .MIN_CYC   (MIN_CYC),
            .STEP_CYC  (STEP_CYC),
            .SLEW_STEP (SLEW_STEP)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en_i     (wr_ok && (servo_num == 6'(i))),
            .wr_pos_i    (servo_pos),
            .commit_i    (commit_d),
            .frame_end_i (frame_end),
            .frame_cnt_i (frame_cnt_q),
            .servo_out_o (servo_out[i]),
            .at_target_o (at_target[i])
        );
    end

    assign commit_pulse = commit_q;
    assign wr_err       = wr_err_q;
    assign frame_start  = frame_start_q;
    assign settled      = settled_q;

endmodule

// File: tb/tb_servo_bank_ctrl.sv
// Directed bench for servo_bank_ctrl on a scaled-down frame:
// 700-cycle frame, pulse = 100 + 2*pos cycles, one slewed and one jump bank.
module tb_servo_bank_ctrl;

    localparam int FR = 700;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] servo_num = '0;
    logic [7:0] servo_pos = '0;
    logic       new_pos = 1'b0;
    logic       trigger = 1'b0;

    logic [3:0] so, so0;
    logic       cp, cp0, we, we0, fs, fs0, st, st0;

    int tests = 0;
    int fails = 0;
    int w[4];
    int w0[4];
    int npulse;

    always #5 clk = ~clk;

    servo_bank_ctrl #(
        .NUM_SERVOS(4), .POS_WIDTH(8), .CLK_RATE(1000000),
        .FRAME_US(FR), .MIN_PULSE_US(100), .MAX_PULSE_US(612),
        .SLEW_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .servo_num(servo_num),
        .servo_pos(servo_pos), .new_pos(new_pos), .trigger(trigger),
        .servo_out(so), .commit_pulse(cp), .wr_err(we),
        .frame_start(fs), .settled(st)
    );

    servo_bank_ctrl #(
        .NUM_SERVOS(4), .POS_WIDTH(8), .CLK_RATE(1000000),
        .FRAME_US(FR), .MIN_PULSE_US(100), .MAX_PULSE_US(612),
        .SLEW_STEP(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .servo_num(servo_num),
        .servo_pos(servo_pos), .new_pos(new_pos), .trigger(trigger),
        .servo_out(so0), .commit_pulse(cp0), .wr_err(we0),
        .frame_start(fs0), .settled(st0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called on the sample right after frame_cnt loads 0; counts
    // high cycles over one full frame and checks the period.
    task automatic measure(input string tag);
        int fe = 0;
        int fe0 = 0;
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            w[k] = 0;
            w0[k] = 0;
        end
        for (int c = 1; c <= FR; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                w[k] += int'(so[k]);
                w0[k] += int'(so0[k]);
            end
            npulse += int'(cp | cp0 | we | we0);
            if (c < FR) begin
                fe += int'(fs);
                fe0 += int'(fs0);
            end
        end
        tests++;
        if (fe !== 0 || fe0 !== 0 || fs !== 1'b1 || fs0 !== 1'b1) begin
            fails++;
            $display("FAIL %s period: early fs %0d/%0d end fs %b/%b, need 0/0 1/1",
                     tag, fe, fe0, fs, fs0);
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            tick();
            n++;
        end while (fs !== 1'b1 && n < FR + 4);
        tests++;
        if (fs !== 1'b1) begin
            fails++;
            $display("FAIL wait_fs: got fs=%b after %0d cycles, need 1", fs, n);
        end
    endtask

    task automatic write(input logic [5:0] n, input logic [7:0] p);
        servo_num = n;
        servo_pos = p;
        new_pos = 1'b1;
        tick();
        new_pos = 1'b0;
    endtask

    // Commit lands on the 3rd edge after trigger rises; an optional
    // write is placed on that same edge.
    task automatic pulse_trigger(input bit wr, input logic [5:0] n,
                                 input logic [7:0] p);
        trigger = 1'b1;
        tick();
        tick();
        tests++;
        if (cp !== 1'b0 || cp0 !== 1'b0) begin
            fails++;
            $display("FAIL commit_early: got %b/%b, need 0/0", cp, cp0);
        end
        if (wr) begin
            servo_num = n;
            servo_pos = p;
            new_pos = 1'b1;
        end
        tick();
        new_pos = 1'b0;
        tests++;
        if (cp !== 1'b1 || cp0 !== 1'b1) begin
            fails++;
            $display("FAIL commit_edge3: got %b/%b, need 1/1", cp, cp0);
        end
        tick();
        tests++;
        if (cp !== 1'b0 || cp0 !== 1'b0) begin
            fails++;
            $display("FAIL commit_width: got %b/%b, need 0/0", cp, cp0);
        end
        trigger = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic check_widths(input string tag, input bit slewed,
                                input int e0, input int e1,
                                input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (slewed && w[k] !== e[k]) begin
                fails++;
                $display("FAIL %s ch%0d width: got %0d, need %0d",
                         tag, k, w[k], e[k]);
            end
            if (!slewed && w0[k] !== e[k]) begin
                fails++;
                $display("FAIL %s jump ch%0d width: got %0d, need %0d",
                         tag, k, w0[k], e[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (so !== 4'h0 || so0 !== 4'h0 || cp !== 1'b0 || we !== 1'b0
            || fs !== 1'b0 || st !== 1'b1 || st0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: so %h/%h cp %b we %b fs %b st %b/%b, need 0/0 0 0 0 1/1",
                     so, so0, cp, we, fs, st, st0);
        end
        rst_n = 1'b1;
        measure("reset");
        check_widths("reset", 1, 356, 356, 356, 356);
        check_widths("reset", 0, 356, 356, 356, 356);
        tests++;
        if (npulse !== 0 || st !== 1'b1) begin
            fails++;
            $display("FAIL reset_quiet: pulses %0d settled %b, need 0 1",
                     npulse, st);
        end
    endtask

    task automatic test_write_trigger();
        write(6'd2, 8'd255);
        wait_fs();
        measure("no_trig");
        check_widths("no_trig", 0, 356, 356, 356, 356);
        pulse_trigger(0, '0, '0);
        tests++;
        if (st0 !== 1'b0) begin
            fails++;
            $display("FAIL settled_drop: got %b, need 0", st0);
        end
        wait_fs();
        measure("commit");
        check_widths("commit", 0, 356, 356, 610, 356);
        tests++;
        if (w[2] !== 364 || st0 !== 1'b1) begin
            fails++;
            $display("FAIL commit_slew ch2: got %0d st0 %b, need 364 1",
                     w[2], st0);
        end
    endtask

    task automatic test_wr_err();
        write(6'd4, 8'd0);
        tests++;
        if (we !== 1'b1 || we0 !== 1'b1) begin
            fails++;
            $display("FAIL wr_err_4: got %b/%b, need 1/1", we, we0);
        end
        tick();
        tests++;
        if (we !== 1'b0) begin
            fails++;
            $display("FAIL wr_err_width: got %b, need 0", we);
        end
        write(6'd63, 8'd0);
        tests++;
        if (we !== 1'b1) begin
            fails++;
            $display("FAIL wr_err_63: got %b, need 1", we);
        end
        write(6'd3, 8'd200);
        tests++;
        if (we !== 1'b0) begin
            fails++;
            $display("FAIL wr_err_valid: got %b, need 0", we);
        end
        write(6'd3, 8'd128);
        pulse_trigger(0, '0, '0);
        wait_fs();
        measure("wr_err");
        check_widths("wr_err", 0, 356, 356, 610, 356);
    endtask

    task automatic test_collision();
        pulse_trigger(1, 6'd1, 8'd10);
        wait_fs();
        measure("collide");
        check_widths("collide", 0, 356, 356, 610, 356);
        pulse_trigger(0, '0, '0);
        wait_fs();
        measure("recommit");
        check_widths("recommit", 0, 356, 120, 610, 356);
    endtask

    task automatic test_reset_mid_pulse();
        wait_fs();
        for (int c = 0; c < 10; c++) tick();
        tests++;
        if (so0 !== 4'hf) begin
            fails++;
            $display("FAIL mid_pulse_high: got %h, need f", so0);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if (so !== 4'h0 || so0 !== 4'h0) begin
            fails++;
            $display("FAIL mid_reset_out: got %h/%h, need 0/0", so, so0);
        end
        tick();
        rst_n = 1'b1;
        measure("rereset");
        check_widths("rereset", 1, 356, 356, 356, 356);
        check_widths("rereset", 0, 356, 356, 356, 356);
    endtask

    task automatic test_slew();
        write(6'd0, 8'd0);
        pulse_trigger(0, '0, '0);
        tests++;
        if (st !== 1'b0) begin
            fails++;
            $display("FAIL slew_unsettled: got %b, need 0", st);
        end
        wait_fs();
        measure("slew1");
        check_widths("slew1", 1, 348, 356, 356, 356);
        check_widths("slew1", 0, 100, 356, 356, 356);
        measure("slew2");
        check_widths("slew2", 1, 340, 356, 356, 356);
        for (int f = 0; f < 28; f++) wait_fs();
        tests++;
        if (st !== 1'b0) begin
            fails++;
            $display("FAIL slew31_settled: got %b, need 0", st);
        end
        wait_fs();
        measure("slew32");
        check_widths("slew32", 1, 100, 356, 356, 356);
        tests++;
        if (st !== 1'b1) begin
            fails++;
            $display("FAIL slew_settled: got %b, need 1", st);
        end
    endtask

    initial begin
        test_reset();
        test_write_trigger();
        test_wr_err();
        test_collision();
        test_reset_mid_pulse();
        test_slew();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
